// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings presented on muldiv_unit.op
//   - FSM state enum (IDLE / CALC / FIX)
//   - md_clog2(): width helper used to size the iteration counter
// Optional feature macro used by the files that import this package:
//   MULDIV_DIV_EN (defined = DIV/DIVU datapath compiled in).
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Number of bits needed to hold values 0..value-1 (minimum 1).
  function automatic int md_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational step of the iterative multiply/divide.
//   Multiply (i_div=0): if acc[0], add i_opnd into the upper half, then shift
//     the whole accumulator right by one with the add carry entering at the top.
//   Divide (i_div=1, MULDIV_DIV_EN only): shift {rem,dividend} left by one,
//     trial-subtract i_opnd from the remainder, restore on borrow, and shift the
//     quotient bit into acc[0].
// Ports:
//   i_div   in  1        step type select
//   i_acc   in  2*WIDTH  accumulator before the step
//   i_opnd  in  WIDTH    multiplicand or divisor
//   o_acc   out 2*WIDTH  accumulator after the step
import muldiv_pkg::*;

module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_acc;

  assign w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
                     (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_acc = {w_sum, i_acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // Remainder is always below the divisor, so the trial value fits in
  // WIDTH+1 bits and bit WIDTH of the difference is a clean borrow flag.
  assign w_trial = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff  = w_trial - {1'b0, i_opnd};
  assign w_ge    = ~w_diff[WIDTH];

  assign o_acc = i_div ? {(w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                          i_acc[WIDTH-2:0], w_ge}
                       : w_mul_acc;
`else
  logic w_unused_div;
  assign w_unused_div = i_div;
  assign o_acc        = w_mul_acc;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO, plus
// single-cycle MTHI/MTLO. Operands are reduced to magnitudes at launch, the
// unsigned core runs N = WIDTH/BITS_PER_CYCLE cycles in CALC, and FIX applies
// the sign correction while writing HI/LO.
// Configuration macro: MULDIV_DIV_EN (undefined = DIV/DIVU only pulse done,
// HI/LO untouched, no divide logic built).
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous, active-high
//   start  in  1      launch op (only when busy=0)
//   op     in  3      operation (see muldiv_pkg)
//   a, b   in  WIDTH  rs / rt operands
//   flush  in  1      abort; wins over start
//   busy   out 1      high in CALC and FIX (pipeline stall request)
//   done   out 1      one-cycle pulse after HI/LO update
//   hi, lo out WIDTH  HI / LO registers
// Handshake: start is sampled on a rising edge only while busy=0; done is a
// single-cycle pulse that coincides with busy=0, so a new start may be
// presented in the done cycle.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = md_clog2(N + 1);

  md_state_e          r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_div;
  logic               r_neg_lo;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic w_launch, w_mt_hi, w_mt_lo, w_nop_done, w_write;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_mt_hi      = 1'b0;
    w_mt_lo      = 1'b0;
    w_nop_done   = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: w_launch = 1'b1;
`ifdef MULDIV_DIV_EN
            MD_DIV, MD_DIVU:   w_launch = 1'b1;
`else
            MD_DIV, MD_DIVU:   w_nop_done = 1'b1;
`endif
            MD_MTHI:           w_mt_hi = 1'b1;
            MD_MTLO:           w_mt_lo = 1'b1;
            default:           ;
          endcase
        end
        if (w_launch) w_next_state = CALC;
      end
      CALC: if (r_cnt == CNT_W'(1)) w_next_state = FIX;
      FIX: begin
        w_write      = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (flush) begin
      w_next_state = IDLE;
      w_launch     = 1'b0;
      w_mt_hi      = 1'b0;
      w_mt_lo      = 1'b0;
      w_nop_done   = 1'b0;
      w_write      = 1'b0;
    end
  end

  // ---------------- operand conditioning ----------------
  logic             w_signed;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -a : a;
  assign w_b_abs  = w_b_neg ? -b : b;

  // ---------------- step chain ----------------
  logic [2*WIDTH-1:0] w_chain [0:BITS_PER_CYCLE];
  assign w_chain[0] = r_acc;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .i_div  (r_div),
      .i_acc  (w_chain[g]),
      .i_opnd (r_opnd),
      .o_acc  (w_chain[g+1])
    );
  end

  // ---------------- sign correction ----------------
  logic [2*WIDTH-1:0] w_res;
  logic [2*WIDTH-1:0] w_prod;

  assign w_prod = r_neg_lo ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
  logic             r_neg_hi;
  logic             r_dz;
  logic [WIDTH-1:0] w_quo, w_rem;

  // Divide by zero: the core leaves the dividend magnitude in the remainder,
  // and re-applying the dividend sign reproduces the raw a for HI.
  assign w_quo = r_dz     ? {WIDTH{1'b1}} :
                 r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_res = r_div ? {w_rem, w_quo} : w_prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_launch) begin
      r_neg_hi <= w_a_neg;
      r_dz     <= (b == '0);
    end
  end
`else
  assign w_res = w_prod;
`endif

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_div    <= 1'b0;
      r_neg_lo <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_write | w_mt_hi | w_mt_lo | w_nop_done;
      if (w_launch) begin
        r_cnt    <= CNT_W'(N);
        r_neg_lo <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
        r_div    <= op[1];
        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_abs : w_b_abs)};
        r_opnd   <= op[1] ? w_b_abs : w_a_abs;
`else
        r_div    <= 1'b0;
        r_acc    <= {{WIDTH{1'b0}}, w_b_abs};
        r_opnd   <= w_a_abs;
`endif
      end else if (r_state == CALC && !flush) begin
        r_acc <= w_chain[BITS_PER_CYCLE];
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_write) begin
        r_hi <= w_res[2*WIDTH-1:WIDTH];
        r_lo <= w_res[WIDTH-1:0];
      end
      if (w_mt_hi) r_hi <= a;
      if (w_mt_lo) r_lo <= a;
    end
  end

  assign busy = (r_state == CALC) || (r_state == FIX);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table-driven checks of muldiv_unit (BITS_PER_CYCLE=1)
// plus hand sequences for flush, ignored start, reset mid-operation and a
// BITS_PER_CYCLE=4 instance with back-to-back launches.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  logic         s4_start, s4_flush;
  logic [2:0]   s4_op;
  logic [W-1:0] s4_a, s4_b;
  logic         s4_busy, s4_done;
  logic [W-1:0] s4_hi, s4_lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(s4_start), .op(s4_op), .a(s4_a), .b(s4_b),
    .flush(s4_flush), .busy(s4_busy), .done(s4_done), .hi(s4_hi), .lo(s4_lo)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one start cycle; returns at the falling edge just after launch.
  task automatic issue1(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done4(output int cyc);
    cyc = 0;
    while (!s4_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] eh, input logic [W-1:0] el, input int lat);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.exp_hi = eh; v.exp_lo = el; v.exp_lat = lat;
    return v;
  endfunction

  initial begin
    int cyc;
    logic [W-1:0] keep_hi, keep_lo;
    bit saw_done;

    reset = 1'b1; start = 0; flush = 0; op = 0; a = 0; b = 0;
    s4_start = 0; s4_flush = 0; s4_op = 0; s4_a = 0; s4_b = 0;

    // Order matters: MTHI/MTLO/disabled-divide expectations carry forward hi/lo.
    vecs.push_back(mk(3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33));
    vecs.push_back(mk(3'b001, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 33));
    vecs.push_back(mk(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33));
    vecs.push_back(mk(3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33));
    vecs.push_back(mk(3'b100, 32'h12345678, 32'd0,        32'h12345678, 32'h00000000, 0));
    vecs.push_back(mk(3'b101, 32'hCAFEF00D, 32'd0,        32'h12345678, 32'hCAFEF00D, 0));
`ifdef MULDIV_DIV_EN
    vecs.push_back(mk(3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       33));
    vecs.push_back(mk(3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33));
    vecs.push_back(mk(3'b011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33));
    vecs.push_back(mk(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33));
    vecs.push_back(mk(3'b010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33));
    vecs.push_back(mk(3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33));
`else
    vecs.push_back(mk(3'b011, 32'd100,      32'd7,        32'h12345678, 32'hCAFEF00D, 0));
    vecs.push_back(mk(3'b010, 32'hFFFFFFF9, 32'd2,        32'h12345678, 32'hCAFEF00D, 0));
`endif

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    // ---------- table-driven vectors ----------
    for (int i = 0; i < vecs.size(); i++) begin
      issue1(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_after_launch", i), {63'd0, busy},
          {63'd0, (vecs[i].exp_lat > 0)});
      wait_done1(cyc);
      chk($sformatf("v%0d_latency", i), 64'(cyc), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_busy_in_done", i), {63'd0, busy}, 64'd0);
      chk($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      chk($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
    end
    keep_hi = vecs[vecs.size()-1].exp_hi;
    keep_lo = vecs[vecs.size()-1].exp_lo;

    // ---------- reserved op: no effect, no done ----------
    issue1(3'b110, 32'h55555555, 32'h1);
    saw_done = 0;
    for (int k = 0; k < 5; k++) begin
      if (done || busy) saw_done = 1;
      @(negedge clk);
    end
    chk("reserved_no_done", {63'd0, saw_done}, 64'd0);
    chk("reserved_hilo", {hi, lo}, {keep_hi, keep_lo});

    // ---------- flush in CALC plus ignored start while busy ----------
    issue1(3'b000, 32'd3, 32'd5);
    saw_done = 0;
    for (int k = 1; k < 10; k++) begin
      if (k == 5) begin start = 1'b1; op = 3'b100; a = 32'hDEADBEEF; end
      else start = 1'b0;
      if (done) saw_done = 1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_drop", {63'd0, busy}, 64'd0);
    for (int k = 0; k < 40; k++) begin
      if (done || busy) saw_done = 1;
      @(negedge clk);
    end
    chk("flush_no_done", {63'd0, saw_done}, 64'd0);
    chk("flush_hilo_kept", {hi, lo}, {keep_hi, keep_lo});

    // ---------- flush together with start in IDLE ----------
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hA5A5A5A5; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_done", {63'd0, done}, 64'd0);
    chk("flush_start_hilo", {hi, lo}, {keep_hi, keep_lo});

    // ---------- reset mid-operation ----------
    issue1(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midreset_no_done_hilo", {31'd0, done, hi}, 64'd0);

    // ---------- BITS_PER_CYCLE=4, back-to-back ----------
    @(negedge clk);
    s4_start = 1'b1; s4_op = 3'b001; s4_a = 32'hFFFFFFFF; s4_b = 32'hFFFFFFFF;
    @(negedge clk);
    s4_start = 1'b0;
    wait_done4(cyc);
    chk("bpc4_latency", 64'(cyc), 64'd9);
    chk("bpc4_multu", {s4_hi, s4_lo}, 64'hFFFFFFFE_00000001);
    chk("bpc4_busy_in_done", {63'd0, s4_busy}, 64'd0);
    // Launch the next op in the done cycle.
    s4_start = 1'b1; s4_op = 3'b000; s4_a = 32'hFFFFFFFD; s4_b = 32'd7;
    @(negedge clk);
    s4_start = 1'b0;
    chk("bpc4_b2b_accepted", {63'd0, s4_busy}, 64'd1);
    wait_done4(cyc);
    chk("bpc4_b2b_latency", 64'(cyc), 64'd9);
    chk("bpc4_b2b_mult", {s4_hi, s4_lo}, 64'hFFFFFFFF_FFFFFFEB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit with architectural HI/LO registers for the 5-stage pipelined MIPS core. It sits beside the EX-stage ALU and executes MULT/MULTU/DIV/DIVU over several cycles. It also performs single-cycle MTHI/MTLO writes. `busy` is the stall request the hazard unit ORs into `stall_IF_ID`, so no MFHI/MFLO or new mul/div leaves ID while an operation is in flight.

## Interface
- WIDTH, 32: operand width; even, ≥4.
- BITS_PER_CYCLE, 1: quotient/product bits retired per cycle; one of 1, 2, 4; must divide WIDTH. N = WIDTH/BITS_PER_CYCLE.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  launch `op` this cycle; honoured only when busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved (ignored, no done).
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO data).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort in-flight operation.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse after HI/LO update.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - latch |a|, |b| for signed ops, raw values for unsigned ops;
  - latch result-sign flags;
  - load iteration counter with N;
  - go to CALC.
- IDLE, start=1, op MTHI/MTLO: write `a` to hi/lo at that edge; done=1 the next cycle; stay IDLE.
- CALC:
  - each cycle retires BITS_PER_CYCLE steps: shift-add multiply, or restoring divide;
  - 2·WIDTH accumulator; counter decrements;
  - counter reaches 0 → FIX.
- FIX: apply sign correction, write hi/lo, go to IDLE, register done=1.
- Multiply: {hi,lo} = full 2·WIDTH product, two's complement for MULT.
- Divide: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
- Divide by zero, DIV or DIVU: lo = all ones, hi = a (raw).
- DIV with a = most-negative and b = −1: lo = most-negative, hi = 0.
- start while busy=1 is ignored.
- flush:
  - in any state, returns to IDLE at the next edge;
  - hi/lo unchanged, no done;
  - flush together with start in IDLE: flush wins, nothing launched.

## Timing
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- Launch edge = E0. busy is high from after E0 to after E(N+1).
- CALC occupies E1..EN. FIX writes hi/lo at E(N+1). done is high in the cycle after E(N+1), with busy already 0.
- Latency: N+1 cycles (33 for WIDTH=32, BITS_PER_CYCLE=1; 9 for BITS_PER_CYCLE=4).
- A new start is accepted in the cycle done is high (back-to-back throughput N+2).
- MTHI/MTLO: hi/lo visible after E0, done in the following cycle, busy never rises.
- Reset asserted mid-operation: immediate return to reset values; any partial result is discarded.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU execute as above.
- MULDIV_DIV_EN undefined:
  - divide datapath is not compiled;
  - DIV/DIVU behave like MTHI/MTLO timing-wise (done next cycle, busy never rises);
  - hi/lo are left unchanged.

## Structure
- Package `muldiv_pkg`:
  - op encodings (MD_MULT … MD_MTLO);
  - state enum (IDLE/CALC/FIX);
  - counter width function clog2(N+1).
- Sub-module `muldiv_iter`: combinational single step.
  - Multiply mode: conditional add plus shift.
  - Divide mode: trial subtract, restore, shift.
  - Instantiated BITS_PER_CYCLE times in a chain inside muldiv_unit.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → done at cycle 33 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low in the done cycle.
- DIVU 100/7 → lo=14, hi=2. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Abort and ignored start:
  - MULT launched, flush in CALC cycle 10 → busy drops next cycle, no done, hi/lo keep prior values;
  - a second start issued while busy is ignored.
- BITS_PER_CYCLE=4, MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done 9 cycles after start. Back-to-back start in the done cycle is accepted.
- MTHI a=0x12345678 → hi updated next edge, done pulse, busy=0 throughout. Without MULD IV_DIV_EN, DIVU 100/7 → done pulse, hi/lo unchanged.
